// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: datapath width, ALU opcodes and FSM states.
// The opcode encoding is common to the decoder, the sequencer and the ALU.
package alu_seq_pkg;

  localparam int ALU_W = 16;

  localparam logic [2:0] OP_LDAC = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_DIV  = 3'd4;
  localparam logic [2:0] OP_MOD  = 3'd5;
  localparam logic [2:0] OP_DBL  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_CAPT,
    S_FLAG,
    S_DONE
  } state_t;

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer driving a registered ALU: one command at a time over valid/ready.
// Optional divide-by-zero rejection is enabled with `define ALU_SEQ_DIVZERO_CHK_EN.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_operand,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_result,
  input  logic         alu_z,
  output logic [W-1:0] ac,
  output logic         z_flag,
  output logic         busy,
  output logic         done,
  output logic         err
);

  state_t       state;
  state_t       state_nxt;
  logic [2:0]   op_q;
  logic [W-1:0] operand_q;
  logic [W-1:0] ac_q;
  logic         z_q;
  logic         accept;
  logic         div_zero;

`ifdef ALU_SEQ_DIVZERO_CHK_EN
  logic err_q;

  assign div_zero = is_div_op(cmd_op) && (cmd_operand == '0);

  // A rejected command goes straight to DONE, so err_q is high exactly in that DONE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && div_zero;
    end
  end

  assign err = err_q;
`else
  assign div_zero = 1'b0;
  assign err      = 1'b0;
`endif

  assign accept  = cmd_valid && cmd_ready;
  assign alu_in1 = ac_q;
  assign alu_in2 = operand_q;
  assign ac      = ac_q;
  assign z_flag  = z_q;
  assign busy    = !cmd_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    alu_op    = 3'd0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_LDAC) begin
            state_nxt = S_LOAD;
          end else if (div_zero) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_LOAD:  state_nxt = S_DONE;
      // The only cycle a non-zero opcode reaches the ALU; zero elsewhere holds its result.
      S_ISSUE: begin
        alu_op    = op_q;
        state_nxt = S_CAPT;
      end
      S_CAPT:  state_nxt = S_FLAG;
      S_FLAG:  state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The ALU zero flag lags its result by a cycle, hence AC in CAPT and the flag in FLAG.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q      <= 3'd0;
      operand_q <= '0;
      ac_q      <= '0;
      z_q       <= 1'b0;
    end else begin
      if (accept) begin
        op_q      <= cmd_op;
        operand_q <= cmd_operand;
      end
      case (state)
        S_LOAD: begin
          ac_q <= operand_q;
          z_q  <= (operand_q == '0);
        end
        S_CAPT:  ac_q <= alu_result;
        S_FLAG:  z_q  <= alu_z;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural registered ALU on the alu_* ports.
// Vectors from a table plus hand-written sequences; results scored through a queue.
`timescale 1ns/1ps
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int W = ALU_W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic [2:0]   cmd_op = 3'd0;
  logic [W-1:0] cmd_operand = '0;
  logic         cmd_ready;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result = '0;
  logic         alu_z = 1'b0;
  logic [W-1:0] ac;
  logic         z_flag;
  logic         busy;
  logic         done;
  logic         err;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_operand(cmd_operand),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_z      (alu_z),
    .ac         (ac),
    .z_flag     (z_flag),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  // Behavioural ALU: result registered when opcode non-zero, zero flag one cycle later.
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    logic [2*W-1:0] prod;
    prod = a * b;
    case (op)
      OP_ADD:  return a + b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return prod[W-1:0];
      OP_DIV:  return (b == '0) ? '1 : a / b;
      OP_MOD:  return (b == '0) ? a : a % b;
      OP_DBL:  return a << 1;
      OP_SUB:  return a - b;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (alu_op != 3'd0) alu_result <= alu_f(alu_in1, alu_in2, alu_op);
    alu_z <= (alu_result == '0);
  end

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] opnd;
    logic [W-1:0] exp_ac;
    logic         exp_z;
    bit           chk_val;
    int           exp_lat;
    int           exp_ops;
    logic         exp_err;
  } rec_t;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] opnd;
    logic [W-1:0] exp_ac;
    logic         exp_z;
  } vec_t;

  rec_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   ops_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [2:0] op, input logic [W-1:0] opnd,
                              input logic [W-1:0] eac, input logic ez);
    rec_t r;
    r.op      = op;
    r.opnd    = opnd;
    r.exp_ac  = eac;
    r.exp_z   = ez;
    r.chk_val = 1'b1;
    r.exp_lat = (op == OP_LDAC) ? 2 : 4;
    r.exp_ops = (op == OP_LDAC) ? 0 : 1;
    r.exp_err = 1'b0;
    return r;
  endfunction

  // Monitor: samples on the falling edge, scores each command when done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_vs_ready", busy, !cmd_ready);
      if (cmd_valid && cmd_ready) begin
        acc_cyc  = cyc;
        ops_seen = 0;
      end
      if (alu_op != 3'd0) begin
        ops_seen++;
        if (sb.size() > 0) begin
          chk("alu_op_val", alu_op, sb[0].op);
          chk("alu_in2_val", alu_in2, sb[0].opnd);
        end else begin
          chk("alu_op_idle", alu_op, 0);
        end
      end
      if (sb.size() > 0 && sb[0].chk_val && sb[0].exp_lat == 4 && cyc == acc_cyc + 3)
        chk("ac_at_t3", ac, sb[0].exp_ac);
      if (done) begin
        if (sb.size() == 0) begin
          chk("done_unexpected", done, 0);
        end else begin
          rec_t r;
          r = sb.pop_front();
          chk("latency", cyc - acc_cyc, r.exp_lat);
          chk("alu_op_pulses", ops_seen, r.exp_ops);
          chk("err_at_done", err, r.exp_err);
          if (r.chk_val) begin
            chk("ac", ac, r.exp_ac);
            chk("z_flag", z_flag, r.exp_z);
          end
        end
      end else if (err) begin
        chk("err_without_done", err, 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [2:0] op, input logic [W-1:0] opnd, input rec_t r,
                      output int waited, output int acyc);
    waited      = 0;
    cmd_valid   = 1'b1;
    cmd_op      = op;
    cmd_operand = opnd;
    while (!cmd_ready && waited < 40) begin
      step();
      waited++;
    end
    acyc = cyc;
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
    end else begin
      sb.push_back(r);
      step();
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    cmd_valid = 1'b0;
    while ((sb.size() != 0 || !cmd_ready) && n < 40) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[14];
    rec_t r;
    int   w1, w2, a1, a2;

    vt = '{
      '{OP_LDAC, 16'h0005, 16'h0005, 1'b0},
      '{OP_ADD,  16'h0003, 16'h0008, 1'b0},
      '{OP_SUB,  16'h0008, 16'h0000, 1'b1},
      '{OP_SUB,  16'h0001, 16'hFFFF, 1'b0},
      '{OP_LDAC, 16'h0100, 16'h0100, 1'b0},
      '{OP_MUL,  16'h0100, 16'h0000, 1'b1},
      '{OP_LDAC, 16'h8001, 16'h8001, 1'b0},
      '{OP_DBL,  16'h1234, 16'h0002, 1'b0},
      '{OP_LDAC, 16'h0000, 16'h0000, 1'b1},
      '{OP_LDAC, 16'd100,  16'd100,  1'b0},
      '{OP_DIV,  16'd7,    16'd14,   1'b0},
      '{OP_MOD,  16'd5,    16'd4,    1'b0},
      '{OP_XOR,  16'h00FF, 16'h00FB, 1'b0},
      '{OP_XOR,  16'h00FB, 16'h0000, 1'b1}
    };

    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_ac", ac, 0);
    chk("rst_z_flag", z_flag, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_in2", alu_in2, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 14; i++) begin
      send(vt[i].op, vt[i].opnd, mk(vt[i].op, vt[i].opnd, vt[i].exp_ac, vt[i].exp_z), w1, a1);
      drain();
    end

    // Divide by zero
    send(OP_LDAC, 16'd7, mk(OP_LDAC, 16'd7, 16'd7, 1'b0), w1, a1);
    drain();
`ifdef ALU_SEQ_DIVZERO_CHK_EN
    r = mk(OP_DIV, 16'd0, 16'd7, 1'b0);
    r.exp_lat = 1;
    r.exp_ops = 0;
    r.exp_err = 1'b1;
`else
    r = mk(OP_DIV, 16'd0, 16'd0, 1'b0);
    r.chk_val = 1'b0;
`endif
    send(OP_DIV, 16'd0, r, w1, a1);
    drain();

    // Back-to-back commands with valid held high
    send(OP_LDAC, 16'd7, mk(OP_LDAC, 16'd7, 16'd7, 1'b0), w1, a1);
    drain();
    send(OP_ADD, 16'd1, mk(OP_ADD, 16'd1, 16'd8, 1'b0), w1, a1);
    send(OP_ADD, 16'd2, mk(OP_ADD, 16'd2, 16'd10, 1'b0), w2, a2);
    drain();
    chk("ready_low_cycles", w2, 4);
    chk("accept_gap", a2 - a1, 5);

    // Reset asserted while the ALU opcode is being issued
    send(OP_LDAC, 16'h1234, mk(OP_LDAC, 16'h1234, 16'h1234, 1'b0), w1, a1);
    drain();
    send(OP_ADD, 16'd5, mk(OP_ADD, 16'd5, 16'h1239, 1'b0), w1, a1);
    cmd_valid = 1'b0;
    chk("issue_before_reset", alu_op, OP_ADD);
    rst_n = 1'b0;
    sb.delete();
    step();
    chk("midrst_ac", ac, 0);
    chk("midrst_alu_op", alu_op, 0);
    chk("midrst_done", done, 0);
    chk("midrst_alu_in2", alu_in2, 0);
    rst_n = 1'b1;
    step();
    chk("midrst_cmd_ready", cmd_ready, 1);
    send(OP_LDAC, 16'd9, mk(OP_LDAC, 16'd9, 16'd9, 1'b0), w1, a1);
    drain();
    send(OP_SUB, 16'd9, mk(OP_SUB, 16'd9, 16'd0, 1'b1), w1, a1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Initiator-side sequencer for the registered 16-bit ALU. Accepts one decoded arithmetic command at a time over a valid/ready handshake, owns the accumulator (AC), and drives the ALU operand and opcode lines. It captures the ALU result into AC and the ALU zero flag into `z_flag`, pulses `done`, and then accepts the next command. It sits between the instruction decoder and the ALU in the processor datapath.

## Interface
Parameters:
- `W`, 16, datapath width. It matches the ALU operand and result width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  the decoder presents a command.
- `cmd_ready`  out  1  high only in IDLE. A command is accepted when `cmd_valid && cmd_ready`.
- `cmd_op`  in  3  0 = LDAC, 1 = ADD, 2 = XOR, 3 = MUL, 4 = DIV, 5 = MOD, 6 = DBL (AC×2), 7 = SUB.
- `cmd_operand`  in  W  register operand, or the load value for LDAC.
- `alu_in1`  out  W  to the ALU first operand; always carries AC.
- `alu_in2`  out  W  to the ALU second operand; the latched command operand.
- `alu_op`  out  3  to the ALU opcode. Non-zero only in ISSUE.
- `alu_result`  in  W  ALU result, registered inside the ALU.
- `alu_z`  in  1  ALU zero flag. It lags `alu_result` by one cycle.
- `ac`  out  W  accumulator.
- `z_flag`  out  1  zero status of the last completed command.
- `busy`  out  1  equals `!cmd_ready`.
- `done`  out  1  one-cycle pulse when a command completes.
- `err`  out  1  one-cycle pulse for a rejected command. Present only with `ALU_SEQ_DIVZERO_CHK_EN`; otherwise tied 0.

## Operation
- Reset values: state IDLE; `ac`=0, `z_flag`=0, `alu_op`=0, `alu_in2`=0, `done`=0, `err`=0; `cmd_ready`=1 once reset is released.
- On accept, latch `cmd_op` and `cmd_operand`. The states are:
- IDLE: `alu_op`=0.
  - LDAC → LOAD.
  - Any other op → ISSUE.
- LOAD: `ac` ← operand; `z_flag` ← (operand == 0); → DONE. The ALU is not used.
- ISSUE: drive `alu_op` = latched op for exactly one cycle; → CAPT.
- CAPT: `alu_op`=0, which makes the ALU hold its result; `ac` ← `alu_result`; → FLAG.
- FLAG: `alu_op`=0; `z_flag` ← `alu_z`; → DONE.
- DONE: `done`=1 for one cycle; → IDLE.
- `alu_op` must be 0 in every state except ISSUE. A non-zero opcode outside ISSUE corrupts `alu_result`/`alu_z`.
- Arithmetic rules are those of the ALU:
  - Results are modulo 2^W.
  - MUL returns the low W bits.
  - DBL ignores `alu_in2`.
  - SUB wraps.
  - DIV and MOD follow the ALU's divide semantics. Divide-by-zero is undefined unless the configuration macro below is enabled.
- `cmd_valid` while busy is ignored. The decoder must hold the command until ready.
- Reset mid-operation: on the next edge, state → IDLE and all outputs take their reset values. The ALU has no reset, so its held `alu_result` may be stale. The controller never reads it outside CAPT.

## Timing
- Accept at cycle T.
  - ALU op: ISSUE at T+1, CAPT at T+2, FLAG at T+3, `done` at T+4; `ac` is valid from T+3 and `z_flag` from T+4. The next accept is possible at T+5.
  - LDAC: LOAD at T+1, `done` at T+2; `ac` and `z_flag` are valid from T+2. The next accept is possible at T+3.
- Throughput: one ALU op per 5 cycles.
- `alu_in1`/`alu_in2` must be stable from ISSUE through the end of CAPT.

## Configuration
- `ALU_SEQ_DIVZERO_CHK_EN`:
  - Defined: DIV or MOD with operand 0 skips ISSUE/CAPT/FLAG. The block goes IDLE → DONE, pulses `err` and `done` together, and leaves `ac` and `z_flag` unchanged. No ALU opcode is driven.
  - Undefined: such commands are issued like any other, and `err` is constant 0.

## Structure
- Shared package `alu_seq_pkg`:
  - opcode constants (LDAC…SUB) shared with the decoder and the ALU;
  - the FSM state enum;
  - W.
- A single module with no sub-module. The FSM and the AC/flag registers are small enough to stay flat.

## Test plan
The bench instantiates the real ALU connected to the `alu_*` ports.
- LDAC 5 at T, then ADD 3 → after the first command `ac`=5, `z_flag`=0; the ADD shows `done` at its T+4 with `ac`=8 and `z_flag`=0; `alu_op`=1 for exactly one cycle.
- With `ac`=8, SUB 8 → `ac`=0, `z_flag`=1. With `ac`=0, SUB 1 → `ac`=0xFFFF, `z_flag`=0.
- LDAC 0x0100, then MUL 0x0100 → `ac`=0x0000 (truncated), `z_flag`=1. DBL with `ac`=0x8001 → `ac`=0x0002.
- With the macro defined: `ac`=7, DIV 0 → `err` and `done` both 1 at T+1, `ac`=7, `alu_op` never non-zero. Without the macro: `err` stays 0.
- `cmd_valid` held high with two commands queued → second accept exactly at T+5; `cmd_ready`=0 from T+1 to T+4.
- `rst_n`=0 during ISSUE → next cycle `ac`=0, `alu_op`=0, `done`=0; `cmd_ready`=1 after `rst_n` is released.
